// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
//   Arbitrates between the instruction-fetch port and the load/store port for
//   the single SPI memory controller. Requests are checked for width and
//   alignment, the controller drive is held stable for the whole transfer, and
//   a registered one-cycle response goes back to the port that won. After each
//   transfer mc_enable is kept low for GAP_CYCLES so the controller returns idle.
//
// Parameters
//   GAP_CYCLES      cycles mc_enable stays low after a transfer (>= 1)
//   TIMEOUT_CYCLES  WAIT cycle limit, used only with MEM_ARB_TIMEOUT_EN
//
// Optional feature macro
//   MEM_ARB_TIMEOUT_EN  abort a transfer with an error response when mc_op_r
//                       has not arrived after TIMEOUT_CYCLES WAIT cycles
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req_valid/if_addr            fetch request (always word read)
//   if_req_ready                    fetch accept pulse
//   if_rsp_valid/_data/_err         fetch response
//   ls_req_valid/ls_addr/ls_we/
//   ls_wdata/ls_mode                load/store request (00 word, 01 byte, 10 half)
//   ls_req_ready                    load/store accept pulse
//   ls_rsp_valid/_data/_err         load/store response
//   mc_enable/_addr/_we/_data_in/
//   mc_instr_mode                   drive to the memory controller
//   mc_data_out, mc_op_r            read data and completion from the controller
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready to arbitrate and accept one request
// S_WAIT    | transfer in flight, mc_* held, waiting for mc_op_r
// S_RELEASE | mc_enable low for GAP_CYCLES so the controller returns idle
// S_ERR     | one-cycle error response for a rejected request

module mem_request_arbiter #(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_valid,
   input  logic [23:0] if_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   input  logic        ls_req_valid,
   input  logic [23:0] ls_addr,
   input  logic        ls_we,
   input  logic [31:0] ls_wdata,
   input  logic [1:0]  ls_mode,
   output logic        ls_req_ready,
   output logic        ls_rsp_valid,
   output logic [31:0] ls_rsp_data,
   output logic        ls_rsp_err,
   output logic        mc_enable,
   output logic [23:0] mc_addr,
   output logic        mc_we,
   output logic [31:0] mc_data_in,
   output logic [1:0]  mc_instr_mode,
   input  logic [31:0] mc_data_out,
   input  logic        mc_op_r
);

   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("GAP_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RELEASE = 2'd2,
      S_ERR     = 2'd3
   } state_t;

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt;
`endif

   state_t            state;
   logic              last_grant;   // 0: fetch won last, 1: load/store won last
   logic [GAP_W-1:0]  gap_cnt;
   logic              pick_if;
   logic              pick_ls;
   logic              if_bad;
   logic              ls_bad;
   logic [31:0]       rd_data;

   always_comb begin
      pick_if = 1'b0;
      pick_ls = 1'b0;
      if (state == S_IDLE && !reset) begin
         if (if_req_valid && ls_req_valid) begin
            pick_ls = ~last_grant;
            pick_if = last_grant;
         end else begin
            pick_if = if_req_valid;
            pick_ls = ls_req_valid;
         end
      end
   end

   assign if_req_ready = pick_if;
   assign ls_req_ready = pick_ls;

   assign if_bad = (if_addr[1:0] != 2'b00);
   assign ls_bad = (ls_mode == 2'b11) ||
                   (ls_mode == 2'b00 && ls_addr[1:0] != 2'b00) ||
                   (ls_mode == 2'b10 && ls_addr[0]);

   // writes return zero data; the controller's output is only meaningful on reads
   assign rd_data = mc_we ? 32'h0 : mc_data_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         last_grant    <= 1'b0;
         gap_cnt       <= '0;
         if_rsp_valid  <= 1'b0;
         if_rsp_data   <= 32'h0;
         if_rsp_err    <= 1'b0;
         ls_rsp_valid  <= 1'b0;
         ls_rsp_data   <= 32'h0;
         ls_rsp_err    <= 1'b0;
         mc_enable     <= 1'b0;
         mc_addr       <= 24'h0;
         mc_we         <= 1'b0;
         mc_data_in    <= 32'h0;
         mc_instr_mode <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         if_rsp_valid <= 1'b0;
         if_rsp_err   <= 1'b0;
         ls_rsp_valid <= 1'b0;
         ls_rsp_err   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pick_ls) begin
                  last_grant    <= 1'b1;
                  mc_addr       <= ls_addr;
                  mc_we         <= ls_we;
                  mc_data_in    <= ls_wdata;
                  mc_instr_mode <= ls_mode;
                  if (ls_bad) begin
                     state        <= S_ERR;
                     ls_rsp_valid <= 1'b1;
                     ls_rsp_err   <= 1'b1;
                     ls_rsp_data  <= 32'h0;
                  end else begin
                     state     <= S_WAIT;
                     mc_enable <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                     to_cnt    <= TO_LOAD;
`endif
                  end
               end else if (pick_if) begin
                  last_grant    <= 1'b0;
                  mc_addr       <= if_addr;
                  mc_we         <= 1'b0;
                  mc_data_in    <= 32'h0;
                  mc_instr_mode <= 2'b00;
                  if (if_bad) begin
                     state        <= S_ERR;
                     if_rsp_valid <= 1'b1;
                     if_rsp_err   <= 1'b1;
                     if_rsp_data  <= 32'h0;
                  end else begin
                     state     <= S_WAIT;
                     mc_enable <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                     to_cnt    <= TO_LOAD;
`endif
                  end
               end
            end

            S_WAIT: begin
               if (mc_op_r) begin
                  state     <= S_RELEASE;
                  mc_enable <= 1'b0;
                  gap_cnt   <= GAP_LOAD;
                  if (last_grant) begin
                     ls_rsp_valid <= 1'b1;
                     ls_rsp_data  <= rd_data;
                  end else begin
                     if_rsp_valid <= 1'b1;
                     if_rsp_data  <= rd_data;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (to_cnt == '0) begin
                  // dropping enable through RELEASE also resets the controller
                  state     <= S_RELEASE;
                  mc_enable <= 1'b0;
                  gap_cnt   <= GAP_LOAD;
                  if (last_grant) begin
                     ls_rsp_valid <= 1'b1;
                     ls_rsp_err   <= 1'b1;
                     ls_rsp_data  <= 32'h0;
                  end else begin
                     if_rsp_valid <= 1'b1;
                     if_rsp_err   <= 1'b1;
                     if_rsp_data  <= 32'h0;
                  end
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
`endif
            end

            S_RELEASE: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            S_ERR: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed scenarios plus a
// randomized run against a behavioural model of arbitration and validation.
module tb_mem_request_arbiter;

   localparam int GAP = 2;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 255;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_valid;
   logic [23:0] if_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        ls_req_valid;
   logic [23:0] ls_addr;
   logic        ls_we;
   logic [31:0] ls_wdata;
   logic [1:0]  ls_mode;
   logic        ls_req_ready;
   logic        ls_rsp_valid;
   logic [31:0] ls_rsp_data;
   logic        ls_rsp_err;
   logic        mc_enable;
   logic [23:0] mc_addr;
   logic        mc_we;
   logic [31:0] mc_data_in;
   logic [1:0]  mc_instr_mode;
   logic [31:0] mc_data_out;
   logic        mc_op_r;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_request_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
      .ls_req_valid(ls_req_valid), .ls_addr(ls_addr), .ls_we(ls_we),
      .ls_wdata(ls_wdata), .ls_mode(ls_mode), .ls_req_ready(ls_req_ready),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
      .mc_enable(mc_enable), .mc_addr(mc_addr), .mc_we(mc_we),
      .mc_data_in(mc_data_in), .mc_instr_mode(mc_instr_mode),
      .mc_data_out(mc_data_out), .mc_op_r(mc_op_r)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req_valid = 1'b0;
      if_addr      = 24'h0;
      ls_req_valid = 1'b0;
      ls_addr      = 24'h0;
      ls_we        = 1'b0;
      ls_wdata     = 32'h0;
      ls_mode      = 2'b00;
      mc_data_out  = 32'h0;
      mc_op_r      = 1'b0;
   endtask

   // leaves the caller just after the negedge of the accept cycle
   task automatic wait_grant(output bit g_if, output bit g_ls, output int waited);
      g_if = 1'b0;
      g_ls = 1'b0;
      waited = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (if_req_ready === 1'b1 || ls_req_ready === 1'b1) begin
            g_if = if_req_ready;
            g_ls = ls_req_ready;
            break;
         end
         waited++;
         step();
      end
   endtask

   // call in a WAIT cycle; returns in the first IDLE cycle afterwards
   task automatic finish_xfer(input logic [31:0] d);
      mc_op_r     = 1'b1;
      mc_data_out = d;
      step();
      mc_op_r     = 1'b0;
      repeat (GAP) step();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      ls_req_valid = 1'b1;
      step();
      step();
      @(negedge clk);
      n_checks++;
      if ({mc_enable, mc_we, mc_instr_mode, if_req_ready, if_rsp_valid, if_rsp_err,
           ls_req_ready, ls_rsp_valid, ls_rsp_err} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0", {mc_enable, mc_we, mc_instr_mode,
                  if_req_ready, if_rsp_valid, if_rsp_err, ls_req_ready, ls_rsp_valid, ls_rsp_err});
      end
      n_checks++;
      if ({mc_addr, mc_data_in, if_rsp_data, ls_rsp_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got addr %h din %h ifd %h lsd %h expected all 0",
                  mc_addr, mc_data_in, if_rsp_data, ls_rsp_data);
      end
      step();
      ls_req_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_tie();
      bit gi, gl;
      int w;
      bit exp_ls;
      if_req_valid = 1'b1; if_addr = 24'h000100;
      ls_req_valid = 1'b1; ls_addr = 24'h000200; ls_mode = 2'b00; ls_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_ls = (k % 2 == 0);
         wait_grant(gi, gl, w);
         n_checks++;
         if ({gi, gl} !== (exp_ls ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL tie_grant_%0d: got if/ls %b%b expected %b", k, gi, gl,
                     exp_ls ? 2'b01 : 2'b10);
         end
         step();
         @(negedge clk);
         n_checks++;
         if (mc_addr !== (exp_ls ? 24'h000200 : 24'h000100)) begin
            n_fail++;
            $display("FAIL tie_addr_%0d: got %h expected %h", k, mc_addr,
                     exp_ls ? 24'h000200 : 24'h000100);
         end
         finish_xfer(32'h5A5A0000 | 32'(k));
      end
      idle_inputs();
   endtask

   task automatic test_word_fetch();
      bit bad = 1'b0;
      if_req_valid = 1'b1; if_addr = 24'h000400;
      @(negedge clk);
      n_checks++;
      if ({if_req_ready, ls_req_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_ready: got if/ls %b%b expected 10", if_req_ready, ls_req_ready);
      end
      step();
      if_req_valid = 1'b0; if_addr = 24'h000ABC;
      for (int i = 0; i <= 130; i++) begin
         if (i == 130) begin
            mc_op_r = 1'b1; mc_data_out = 32'hDEADBEEF;
         end
         @(negedge clk);
         if (mc_enable !== 1'b1 || mc_addr !== 24'h000400 || mc_we !== 1'b0 ||
             mc_instr_mode !== 2'b00 || if_rsp_valid !== 1'b0) bad = 1'b1;
         step();
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL fetch_hold: mc drive changed during WAIT, last en %b addr %h we %b mode %b",
                  mc_enable, mc_addr, mc_we, mc_instr_mode);
      end
      // W+1: response; a new request now must wait for IDLE
      mc_op_r = 1'b0; mc_data_out = 32'h11111111;
      ls_req_valid = 1'b1; ls_addr = 24'h000500; ls_mode = 2'b00; ls_we = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL fetch_rsp: got v %b e %b d %h expected v 1 e 0 d deadbeef",
                  if_rsp_valid, if_rsp_err, if_rsp_data);
      end
      n_checks++;
      if ({mc_enable, ls_rsp_valid, ls_req_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL fetch_w1: got en/lsv/lsrdy %b expected 000",
                  {mc_enable, ls_rsp_valid, ls_req_ready});
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({mc_enable, if_rsp_valid, ls_req_ready} !== 3'b000 || if_rsp_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL fetch_w2: got en/ifv/lsrdy %b data %h expected 000 deadbeef",
                  {mc_enable, if_rsp_valid, ls_req_ready}, if_rsp_data);
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({mc_enable, ls_req_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL fetch_gap_end: got en/lsrdy %b expected 01", {mc_enable, ls_req_ready});
      end
      step();
      ls_req_valid = 1'b0;
      finish_xfer(32'h0);
   endtask

   task automatic test_byte_store();
      bit gi, gl, bad;
      int w;
      bad = 1'b0;
      ls_req_valid = 1'b1; ls_addr = 24'h000301; ls_mode = 2'b01;
      ls_wdata = 32'h000000A5; ls_we = 1'b1;
      wait_grant(gi, gl, w);
      n_checks++;
      if ({gi, gl} !== 2'b01) begin
         n_fail++;
         $display("FAIL store_grant: got if/ls %b%b expected 01", gi, gl);
      end
      step();
      ls_req_valid = 1'b0; ls_wdata = 32'hFFFFFFFF; ls_mode = 2'b00; ls_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            mc_op_r = 1'b1; mc_data_out = 32'h12345678;
         end
         @(negedge clk);
         if (mc_enable !== 1'b1 || mc_data_in !== 32'h000000A5 || mc_we !== 1'b1 ||
             mc_instr_mode !== 2'b01 || mc_addr !== 24'h000301) bad = 1'b1;
         step();
      end
      mc_op_r = 1'b0;
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL store_hold: got din %h we %b mode %b expected a5 1 01",
                  mc_data_in, mc_we, mc_instr_mode);
      end
      @(negedge clk);
      n_checks++;
      if ({ls_rsp_valid, ls_rsp_err, ls_rsp_data, if_rsp_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL store_rsp: got v %b e %b d %h ifv %b expected 1 0 0 0",
                  ls_rsp_valid, ls_rsp_err, ls_rsp_data, if_rsp_valid);
      end
      repeat (GAP) step();
   endtask

   task automatic test_illegal();
      bit gi, gl, en_seen, is_ls;
      int w;
      logic [23:0] addrs [3];
      logic [1:0]  modes [3];
      logic [33:0] got;
      logic        other;
      addrs[0] = 24'h000010; modes[0] = 2'b11;
      addrs[1] = 24'h000003; modes[1] = 2'b10;
      addrs[2] = 24'h000002; modes[2] = 2'b00;
      en_seen = 1'b0;
      // leave non-zero response data on both ports beforehand
      ls_req_valid = 1'b1; ls_addr = 24'h000008; ls_mode = 2'b00; ls_we = 1'b0;
      wait_grant(gi, gl, w);
      step();
      ls_req_valid = 1'b0;
      finish_xfer(32'hCAFEF00D);
      for (int c = 0; c < 3; c++) begin
         is_ls = (c < 2);
         if (is_ls) begin
            ls_req_valid = 1'b1; ls_addr = addrs[c]; ls_mode = modes[c]; ls_we = c[0];
         end else begin
            if_req_valid = 1'b1; if_addr = addrs[c];
         end
         wait_grant(gi, gl, w);
         en_seen |= mc_enable;
         n_checks++;
         if ({gi, gl} !== (is_ls ? 2'b01 : 2'b10) || (c > 0 && w != 0)) begin
            n_fail++;
            $display("FAIL illegal_accept_%0d: got if/ls %b%b after %0d cycles expected %b after 0",
                     c, gi, gl, w, is_ls ? 2'b01 : 2'b10);
         end
         step();
         ls_req_valid = 1'b0; if_req_valid = 1'b0;
         @(negedge clk);
         en_seen |= mc_enable;
         got   = is_ls ? {ls_rsp_valid, ls_rsp_err, ls_rsp_data} : {if_rsp_valid, if_rsp_err, if_rsp_data};
         other = is_ls ? if_rsp_valid : ls_rsp_valid;
         n_checks++;
         if (got !== {1'b1, 1'b1, 32'h0} || other !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_rsp_%0d: got v/e/d %h other %b expected 3_00000000 other 0",
                     c, got, other);
         end
         step();
      end
      @(negedge clk);
      en_seen |= mc_enable;
      n_checks++;
      if (en_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_enable: got enable seen %b expected 0", en_seen);
      end
      step();
   endtask

   task automatic test_reset_mid_wait();
      bit gi, gl, bad;
      int w;
      bad = 1'b0;
      ls_req_valid = 1'b1; ls_addr = 24'h000020; ls_mode = 2'b00; ls_we = 1'b0;
      wait_grant(gi, gl, w);
      step();
      ls_req_valid = 1'b0;
      repeat (10) step();
      reset = 1'b1;
      mc_op_r = 1'b1; mc_data_out = 32'h87654321;
      step();
      reset = 1'b0;
      mc_op_r = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mc_enable, if_rsp_valid, ls_rsp_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstwait_drop: got en/ifv/lsv %b expected 000",
                  {mc_enable, if_rsp_valid, ls_rsp_valid});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0 || mc_enable !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL rstwait_quiet: got activity after reset, ifv %b lsv %b en %b expected 0",
                  if_rsp_valid, ls_rsp_valid, mc_enable);
      end
      step();
      if_req_valid = 1'b1; if_addr = 24'h000030;
      ls_req_valid = 1'b1; ls_addr = 24'h000034;
      wait_grant(gi, gl, w);
      n_checks++;
      if ({gi, gl} !== 2'b01) begin
         n_fail++;
         $display("FAIL rstwait_tie: got if/ls %b%b expected 01", gi, gl);
      end
      step();
      idle_inputs();
      finish_xfer(32'h0);
   endtask

   task automatic test_timeout();
      bit gi, gl, bad;
      int w;
      bad = 1'b0;
      // leave non-zero fetch data beforehand
      if_req_valid = 1'b1; if_addr = 24'h000040;
      wait_grant(gi, gl, w);
      step();
      if_req_valid = 1'b0;
      finish_xfer(32'h0BADF00D);
      if_req_valid = 1'b1; if_addr = 24'h000044;
      wait_grant(gi, gl, w);
      n_checks++;
      if ({gi, gl} !== 2'b10) begin
         n_fail++;
         $display("FAIL timeout_grant: got if/ls %b%b expected 10", gi, gl);
      end
      step();
      if_req_valid = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         if (mc_enable !== 1'b1 || if_rsp_valid !== 1'b0) bad = 1'b1;
         step();
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL timeout_wait: got early abort or enable drop, en %b ifv %b", mc_enable, if_rsp_valid);
      end
      @(negedge clk);
      n_checks++;
      if ({if_rsp_valid, if_rsp_err, if_rsp_data, mc_enable} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL timeout_rsp: got v %b e %b d %h en %b expected 1 1 0 0",
                  if_rsp_valid, if_rsp_err, if_rsp_data, mc_enable);
      end
      step();
      if_req_valid = 1'b1; if_addr = 24'h000048;
      @(negedge clk);
      n_checks++;
      if ({mc_enable, if_rsp_valid, if_req_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL timeout_gap: got en/ifv/rdy %b expected 000",
                  {mc_enable, if_rsp_valid, if_req_ready});
      end
      step();
      @(negedge clk);
      n_checks++;
      if (if_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_gap_end: got ready %b expected 1", if_req_ready);
      end
      step();
      if_req_valid = 1'b0;
      finish_xfer(32'h0);
`else
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (mc_enable !== 1'b1 || if_rsp_valid !== 1'b0) bad = 1'b1;
         step();
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL no_timeout: got en %b ifv %b within 1000 cycles expected 1 0",
                  mc_enable, if_rsp_valid);
      end
      finish_xfer(32'h0);
`endif
   endtask

   task automatic test_random();
      bit p_if, p_ls, gi, gl, exp_ls, exp_err, last_ls;
      logic [23:0] a_if, a_ls, e_addr;
      logic [1:0]  m_ls;
      logic        we_ls;
      logic [31:0] wd_ls, r, d;
      logic [33:0] got;
      logic [33:0] exp_rsp;
      logic        other;
      int w, lat;
      p_if = 1'b0; p_ls = 1'b0;
      last_ls = 1'b0;   // after reset the fetch port counts as the last winner
      a_if = '0; a_ls = '0; m_ls = '0; we_ls = 1'b0; wd_ls = '0;
      for (int t = 0; t < 60; t++) begin
         if (!p_if && $urandom_range(1, 0) == 1) begin
            p_if = 1'b1;
            r = $urandom();
            a_if = r[23:0];
            if ($urandom_range(3, 0) != 0) a_if[1:0] = 2'b00;
         end
         if (!p_ls && ($urandom_range(1, 0) == 1 || !p_if)) begin
            p_ls = 1'b1;
            r = $urandom();
            a_ls = r[23:0];
            m_ls = 2'($urandom_range(3, 0));
            if ($urandom_range(9, 0) < 7) a_ls[1:0] = 2'b00;
            we_ls = ($urandom_range(1, 0) == 1);
            wd_ls = $urandom();
         end
         if_req_valid = p_if; if_addr = a_if;
         ls_req_valid = p_ls; ls_addr = a_ls; ls_mode = m_ls; ls_we = we_ls; ls_wdata = wd_ls;

         exp_ls  = (p_if && p_ls) ? !last_ls : p_ls;
         last_ls = exp_ls;
         if (exp_ls)
            exp_err = (m_ls == 2'b11) || (m_ls == 2'b00 && (a_ls % 4) != 0) ||
                      (m_ls == 2'b10 && (a_ls % 2) != 0);
         else
            exp_err = (a_if % 4) != 0;

         wait_grant(gi, gl, w);
         n_checks++;
         if ({gi, gl} !== (exp_ls ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL rand_grant_%0d: got if/ls %b%b expected %b", t, gi, gl,
                     exp_ls ? 2'b01 : 2'b10);
         end
         step();
         if (exp_ls) begin
            p_ls = 1'b0; ls_req_valid = 1'b0;
         end else begin
            p_if = 1'b0; if_req_valid = 1'b0;
         end

         if (exp_err) begin
            @(negedge clk);
            got   = exp_ls ? {ls_rsp_valid, ls_rsp_err, ls_rsp_data} : {if_rsp_valid, if_rsp_err, if_rsp_data};
            other = exp_ls ? if_rsp_valid : ls_rsp_valid;
            n_checks++;
            if (got !== {1'b1, 1'b1, 32'h0} || other !== 1'b0 || mc_enable !== 1'b0) begin
               n_fail++;
               $display("FAIL rand_err_%0d: got v/e/d %h other %b en %b expected 3_00000000 0 0",
                        t, got, other, mc_enable);
            end
            step();
         end else begin
            e_addr = exp_ls ? a_ls : a_if;
            @(negedge clk);
            n_checks++;
            if (mc_enable !== 1'b1 || mc_addr !== e_addr || mc_we !== (exp_ls & we_ls) ||
                mc_instr_mode !== (exp_ls ? m_ls : 2'b00) ||
                (exp_ls && mc_data_in !== wd_ls)) begin
               n_fail++;
               $display("FAIL rand_drive_%0d: got en %b addr %h we %b mode %b din %h expected 1 %h %b %b %h",
                        t, mc_enable, mc_addr, mc_we, mc_instr_mode, mc_data_in, e_addr,
                        exp_ls & we_ls, exp_ls ? m_ls : 2'b00, wd_ls);
            end
            lat = $urandom_range(5, 0);
            repeat (lat) step();
            d = $urandom();
            mc_op_r = 1'b1; mc_data_out = d;
            step();
            mc_op_r = 1'b0; mc_data_out = $urandom();
            @(negedge clk);
            got     = exp_ls ? {ls_rsp_valid, ls_rsp_err, ls_rsp_data} : {if_rsp_valid, if_rsp_err, if_rsp_data};
            other   = exp_ls ? if_rsp_valid : ls_rsp_valid;
            exp_rsp = {1'b1, 1'b0, (exp_ls && we_ls) ? 32'h0 : d};
            n_checks++;
            if (got !== exp_rsp || other !== 1'b0 || mc_enable !== 1'b0) begin
               n_fail++;
               $display("FAIL rand_rsp_%0d: got v/e/d %h other %b en %b expected %h 0 0",
                        t, got, other, mc_enable, exp_rsp);
            end
            repeat (GAP) step();
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_word_fetch();
      test_byte_store();
      test_illegal();
      test_reset_mid_wait();
      test_timeout();
      test_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Two-port request arbiter between the core's instruction-fetch port and its load/store port, feeding the single SPI memory controller. It accepts requests with valid/ready handshakes and checks width and alignment. It drives the controller's `enable`/`addr`/`we`/`data_in`/`instr_mode` stable for the whole transfer, waits for `op_r`, and returns a registered one-cycle response to the winning port. It also enforces an idle gap on `enable` between transfers so the controller returns to its idle state.

## Interface
- `GAP_CYCLES`, default 2: cycles `mc_enable` is held low after each transfer (minimum 1).
- `TIMEOUT_CYCLES`, default 255: WAIT-state cycle limit; only used with `MEM_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req_valid` in 1: fetch request. `if_addr` in 24: fetch address; fetch is always word mode and read.
- `if_req_ready` out 1: one-cycle pulse when the fetch request is accepted.
- `if_rsp_valid` out 1, `if_rsp_data` out 32, `if_rsp_err` out 1: fetch response.
- `ls_req_valid` in 1, `ls_addr` in 24, `ls_we` in 1, `ls_wdata` in 32: load/store request.
- `ls_mode` in 2: access width; 00 = word, 01 = byte, 10 = half, 11 = illegal.
- `ls_req_ready` out 1, `ls_rsp_valid` out 1, `ls_rsp_data` out 32, `ls_rsp_err` out 1: load/store handshake and response.
- `mc_enable` out 1, `mc_addr` out 24, `mc_we` out 1, `mc_data_in` out 32, `mc_instr_mode` out 2: drive to the controller.
- `mc_data_out` in 32, `mc_op_r` in 1: from the controller.

## Operation
States: IDLE, WAIT, RELEASE, ERR.

**IDLE**
- Arbitration uses round-robin via a `last_grant` bit. `last_grant` resets to fetch, so the load/store port wins the first tie.
- A single valid request always wins.
- The winner receives a `*_req_ready` pulse, and its payload is latched into the `mc_*` registers.
- If the request fails validation, go to ERR. Otherwise go to WAIT with `mc_enable=1`.
- `last_grant` is updated on every accept, including error accepts.

**Validation failures**
- `ls_mode`==11.
- Word access with `addr[1:0]`≠0.
- Half access with `addr[0]`=1.
- Fetch with `if_addr[1:0]`≠0.

**WAIT**
- All `mc_*` outputs are held constant.
- On the first cycle `mc_op_r`=1: capture `mc_data_out` (0 for writes), deassert `mc_enable`, and go to RELEASE.
- The response is raised on the granted port with `*_rsp_err`=0.

**ERR**
- One cycle. `*_rsp_valid`=1, `*_rsp_err`=1, `*_rsp_data`=0.
- `mc_enable` is never raised. Next state is IDLE.

**RELEASE**
- `mc_enable`=0 for `GAP_CYCLES` cycles, then go to IDLE.
- `mc_op_r` is ignored in this state.

**Requester and response rules**
- Requesters must hold valid and payload until ready. `*_req_ready` is 0 in every state except the IDLE accept cycle.
- Responses are always accepted; there is no backpressure. Response data is registered and holds its value until the next response.
- Only the granted port's response signals are ever asserted.

**Reset values and reset mid-operation**
- Reset values: every output is 0, including `mc_instr_mode`=00. State is IDLE and `last_grant` is fetch.
- On reset in any state, including mid-WAIT, `mc_enable` drops in the next cycle and no response is issued.

## Timing
- Accept at cycle T. `mc_enable`=1 and `mc_*` are valid from T+1.
- If `mc_op_r` is first sampled high at cycle W: `*_rsp_valid` is high at W+1, and `mc_enable` is low from W+1 through W+`GAP_CYCLES`.
- The earliest next accept is W+`GAP_CYCLES`+1.
- Error path: accept at T, error response at T+1, earliest next accept at T+2.
- Minimum controller-facing throughput: one transfer per (transfer length + `GAP_CYCLES` + 1) cycles.
- A request that arrives in the same cycle a response is issued is not accepted until IDLE.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A counter runs during WAIT. If `mc_op_r` has not arrived after `TIMEOUT_CYCLES` cycles, abort the transfer.
  - Abort response: `*_rsp_valid`=1, `*_rsp_err`=1, `*_rsp_data`=0.
  - Then go to RELEASE, which drops `mc_enable` and resets the controller.
  - The counter clears on every entry to WAIT.
- **`MEM_ARB_TIMEOUT_EN` undefined:** WAIT lasts indefinitely until `mc_op_r`, and there is no counter logic.

## Test plan
- **Word fetch:** fetch `if_addr`=0x000400; the controller model raises `mc_op_r` 130 cycles later with `mc_data_out`=0xDEADBEEF.
  - Required: `if_rsp_valid` at W+1 with data 0xDEADBEEF and err 0.
  - Required: `mc_instr_mode`=00 and `mc_we`=0 for the whole transfer.
  - Required: `mc_enable` low for exactly 2 cycles afterwards.
- **Tie arbitration:** both ports request at the same time after reset.
  - Required: the load/store port is granted first, then fetch.
  - Repeat the tie: grants alternate.
- **Byte store:** `ls_addr`=0x000301, `ls_mode`=01, `ls_wdata`=0x000000A5, `ls_we`=1.
  - Required: `mc_data_in`=0x000000A5, `mc_we`=1, `mc_instr_mode`=01 held through WAIT.
  - Required: `ls_rsp_err`=0 and `ls_rsp_data`=0.
- **Illegal requests:** `ls_mode`=11; half access at address 0x000003; fetch at 0x000002.
  - Required: each gets an error response at T+1.
  - Required: `mc_enable` never rises.
- **Reset mid-WAIT:** assert `reset` 10 cycles into WAIT.
  - Required: `mc_enable`=0 on the next cycle and no `*_rsp_valid`.
  - Required: the next tie is granted to the load/store port.
- **Timeout** (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): `mc_op_r` is never raised.
  - Required: error response with data 0 after 16 WAIT cycles, then the `GAP_CYCLES` idle gap.
  - Without the macro: still in WAIT at 1000 cycles.
